// File: rtl/io_port_pkg.sv
// Shared constants and types for the core-side IN/OUT port controller.
package io_port_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 4;

  // Core-side opcodes that the execute stage decodes into out_we / in_re.
  localparam logic [5:0] OP_IN  = 6'b010110;
  localparam logic [5:0] OP_OUT = 6'b010111;

  localparam int ERR_OUT_OVF = 1;
  localparam int ERR_IN_UDF  = 0;

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/io_tx_fifo.sv
// TX FIFO: OUT words queued here and drained over a valid/ready handshake.
module io_tx_fifo
  import io_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_ready_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop, accept;

  // A pop frees the slot this edge, so a full FIFO can still take a push.
  assign pop    = (count_q != '0) & pop_ready_i;
  assign accept = push_i & ((count_q != CW'(DEPTH)) | pop);
  assign ovf_o  = push_i & ~accept;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/io_port_ctrl.sv
// Peripheral endpoint for the core's IN/OUT path: TX FIFO plus one-entry RX holding register.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   out_we,
  input  logic [WIDTH-1:0]       out_data,
  output logic                   out_full,
  output logic [$clog2(DEPTH):0] out_count,
  output logic                   ext_tx_valid,
  output logic [WIDTH-1:0]       ext_tx_data,
  input  logic                   ext_tx_ready,
  input  logic                   ext_rx_valid,
  input  logic [WIDTH-1:0]       ext_rx_data,
  output logic                   ext_rx_ready,
  input  logic                   in_re,
  output logic [WIDTH-1:0]       data_in,
  output logic                   in_avail,
  output logic [1:0]             err_flags,
  input  logic                   clr_err
);

  logic             tx_ovf;
  rx_state_e        rx_state_q, rx_state_d;
  logic             rx_ready_q, rx_ready_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [1:0]       err_q, err_d;
  logic             capture, underflow;

  io_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (out_we),
    .push_data_i (out_data),
    .pop_ready_i (ext_tx_ready),
    .valid_o     (ext_tx_valid),
    .head_o      (ext_tx_data),
    .full_o      (out_full),
    .count_o     (out_count),
    .ovf_o       (tx_ovf)
  );

  assign capture   = (rx_state_q == RX_EMPTY) & rx_ready_q & ext_rx_valid;
  assign underflow = (rx_state_q == RX_EMPTY) & in_re;

  // Ready comes from a flop, so a read only re-opens the port one edge later.
  always_comb begin
    rx_state_d = rx_state_q;
    din_d      = din_q;
    if (capture) begin
      rx_state_d = RX_FULL;
      din_d      = ext_rx_data;
    end else if ((rx_state_q == RX_FULL) && in_re) begin
      rx_state_d = RX_EMPTY;
    end
    rx_ready_d = (rx_state_d == RX_EMPTY);

    err_d = clr_err ? 2'b00 : err_q;
    if (tx_ovf)    err_d[ERR_OUT_OVF] = 1'b1;
    if (underflow) err_d[ERR_IN_UDF]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_EMPTY;
      rx_ready_q <= 1'b0;
      din_q      <= '0;
      err_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_ready_q <= rx_ready_d;
      din_q      <= din_d;
      err_q      <= err_d;
    end
  end

  assign ext_rx_ready = rx_ready_q;
  assign in_avail     = (rx_state_q == RX_FULL);
  assign data_in      = din_q;
  assign err_flags    = err_q;

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Peripheral-side endpoint of the core's IN/OUT instruction path.
- OUT direction: accepts words the execute stage emits on OUT, buffers them in a small TX FIFO, and drains them to an external device over a valid/ready handshake.
- IN direction: accepts words from an external device over valid/ready into a one-entry holding register, which the execute stage reads on IN.
- Sits between the execute stage and the board-level I/O pins, in the same clock domain.

Parameters:
- DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- WIDTH, 16, data word width; matches the datapath.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- out_we  input  1  one-cycle push strobe; core asserts it on OUT (op 6'b010111).
- out_data  input  WIDTH  word to transmit; sampled when out_we=1.
- out_full  output  1  TX FIFO full; core stalls OUT while high.
- out_count  output  clog2(DEPTH)+1  TX FIFO occupancy.
- ext_tx_valid  output  1  TX word available.
- ext_tx_data  output  WIDTH  TX FIFO head; 16'h0000 when ext_tx_valid=0.
- ext_tx_ready  input  1  external sink accepts the head word.
- ext_rx_valid  input  1  external source presents a word.
- ext_rx_data  input  WIDTH  incoming word.
- ext_rx_ready  output  1  holding register can accept a word.
- in_re  input  1  one-cycle read strobe; core asserts it on IN (op 6'b010110).
- data_in  output  WIDTH  holding register contents; feeds the ALU data_in.
- in_avail  output  1  holding register holds an unread word.
- err_flags  output  2  sticky {out_overflow, in_underflow}.
- clr_err  input  1  clears err_flags on the next edge.

Behaviour:
- Reset (reset=0, asynchronous):
  - Cleared: TX pointers, count, holding register, data_in=0, in_avail=0, err_flags=00.
  - Outputs during reset: ext_tx_valid=0, ext_tx_data=0, ext_rx_ready=0, out_full=0, out_count=0.
  - FIFO storage array is not reset.
  - ext_rx_ready rises on the first posedge after reset deasserts.
  - Reset mid-transfer discards queued TX words and the held RX word; no partial handshake survives.
- TX FIFO:
  - pop = ext_tx_valid & ext_tx_ready.
  - push accepted = out_we & (count<DEPTH | pop).
  - Full with simultaneous pop: the push is accepted and count stays at DEPTH.
  - Rejected push (out_we while full, no pop): data dropped, count unchanged, err_flags[1] set.
  - Pointers wrap modulo DEPTH. count changes by +1 (push only), -1 (pop only), 0 (both or neither).
  - ext_tx_valid = (count!=0); ext_tx_data = head entry.
  - Latency: push at edge N into an empty FIFO gives ext_tx_valid=1 with that word immediately after edge N.
  - Ordering is strict FIFO.
  - ext_tx_data must hold stable while ext_tx_valid=1 & ext_tx_ready=0.
- RX holding register, two states:
  - EMPTY: ext_rx_ready=1, in_avail=0. On ext_rx_valid, capture ext_rx_data into data_in and go to FULL.
  - FULL: ext_rx_ready=0, in_avail=1. On in_re, go to EMPTY; data_in keeps its last value.
  - ext_rx_ready is registered (no combinational path from in_re). A consecutive read-then-refill therefore costs one bubble cycle.
  - Latency: capture at edge N gives data_in and in_avail valid after edge N.
  - in_re in EMPTY: no state change, data_in unchanged, err_flags[0] set.
- Error flags:
  - Sticky until clr_err.
  - clr_err and a new error in the same cycle: the flag is set (set wins).
- out_we and in_re in the same cycle are independent. Each direction is evaluated separately.

Decomposition:
- Shared package io_port_pkg:
  - WIDTH and DEPTH defaults.
  - OP_IN=6'b010110, OP_OUT=6'b010111 (core-side strobe decode).
  - Error bit indices ERR_OUT_OVF=1, ERR_IN_UDF=0.
- One sub-module io_tx_fifo: storage, pointers, count, push/pop rules.
- The RX holding register and error logic stay in the top module.

Test Plan:
- Reset then idle: out_count=0, ext_tx_valid=0, ext_rx_ready=1 after the first edge, data_in=0, err_flags=00.
- TX order/backpressure: push 16'h1111, 16'h2222, 16'h3333 with ext_tx_ready=0. Then:
  - out_count=3 and ext_tx_data=16'h1111 held stable.
  - Raise ext_tx_ready: words appear in order, one per cycle; ext_tx_valid falls after the third.
- Full/overflow: push 5 words (DEPTH=4) with ext_tx_ready=0.
  - out_full=1 after the 4th push.
  - 5th word 16'hDEAD dropped; err_flags=10.
  - Full plus push plus pop in one cycle: accepted, count stays 4.
- RX path: drive ext_rx_valid with 16'hBEEF.
  - data_in=16'hBEEF, in_avail=1, ext_rx_ready=0 next cycle.
  - Second word 16'hCAFE is held off until in_re. in_avail drops, one bubble, then 16'hCAFE is captured.
- Underflow/clear: in_re while in_avail=0 sets err_flags=01 and leaves data_in unchanged. clr_err with no new error returns 00; clr_err with a simultaneous underflow keeps 01.
- Async reset mid-operation: assert reset between edges with 2 TX words queued and RX FULL. Outputs clear immediately, without waiting for clk.
